// File: rtl/wb_bridge_pkg.sv
// Shared types and elaboration checks for the core-to-Wishbone memory bridge.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } bridge_state_e;

    localparam int unsigned MaxRespStages = 3;

    function automatic bit resp_stages_legal(int unsigned stages);
        return stages <= MaxRespStages;
    endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-depth delay line for bridge responses; depth 0 is a wire.
module wb_resp_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter type         rsp_t = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  rsp_t rsp_i,
    output rsp_t rsp_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign rsp_o          = rsp_i;
    end else begin : g_stages
        rsp_t stage_q [DEPTH];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= rsp_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign rsp_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/wb_mem_bridge.sv
// Native core memory port to Wishbone master (classic or pipelined), one access in flight,
// with bus-error/timeout reporting and a configurable response delay.
module wb_mem_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned PIPELINED      = 1,
    parameter int unsigned RESP_STAGES    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic [SEL_WIDTH-1:0]  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  req_ready_o,
    output logic                  stall_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_stall_i
);

    if (!resp_stages_legal(RESP_STAGES)) begin : g_bad_resp_stages
        $error("wb_mem_bridge: RESP_STAGES must be in 0..3");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("wb_mem_bridge: DATA_WIDTH must be a multiple of 8");
    end

    localparam int unsigned TimeoutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimeoutW-1:0] TimeoutLast =
        TimeoutW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    bridge_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SEL_WIDTH-1:0]  mask_q, mask_d;
    logic [TimeoutW-1:0]   tmo_q, tmo_d;
    logic                  stall_q, stall_d;
    logic                  bus_rsp, timed_out, is_read;
    rsp_t                  rsp_in, rsp_out;

    assign bus_rsp   = wb_ack_i | wb_err_i;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (tmo_q == TimeoutLast);
    assign is_read   = (mask_q == '0);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        tmo_d       = tmo_q;
        req_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        rsp_in      = '0;

        unique case (state_q)
            StIdle: begin
                // Holding off while a delayed response is still in the pipe keeps one in flight.
                if (req_valid_i && !stall_q) begin
                    req_ready_o = 1'b1;
                    addr_d      = req_addr_i;
                    wdata_d     = req_wdata_i;
                    mask_d      = req_we_i;
                    tmo_d       = '0;
                    state_d     = StReq;
                end
            end
            StReq, StWait: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = (state_q == StReq);
                if (bus_rsp) begin
                    rsp_in.valid = 1'b1;
                    rsp_in.err   = wb_err_i;
                    rsp_in.data  = (is_read && !wb_err_i) ? wb_dat_i : '0;
                    state_d      = StDone;
                end else if (timed_out) begin
                    rsp_in.valid = 1'b1;
                    rsp_in.err   = 1'b1;
                    state_d      = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (state_q == StReq && PIPELINED != 0 && !wb_stall_i) begin
                        state_d = StWait;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        stall_d = stall_q ? !rsp_out.valid : req_ready_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            tmo_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
        end
    end

    wb_resp_pipe #(
        .DEPTH (RESP_STAGES),
        .rsp_t (rsp_t)
    ) u_resp_pipe (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .rsp_i  (rsp_in),
        .rsp_o  (rsp_out)
    );

    assign wb_we_o     = wb_cyc_o && !is_read;
    assign wb_sel_o    = !wb_cyc_o ? '0 : (is_read ? {SEL_WIDTH{1'b1}} : mask_q);
    assign wb_adr_o    = addr_q;
    assign wb_dat_o    = wdata_q;
    assign stall_o     = stall_q;
    assign rsp_valid_o = rsp_out.valid;
    assign rsp_err_o   = rsp_out.err;
    assign rsp_rdata_o = rsp_out.data;

endmodule
